// File: rtl/fetch_pc_unit.sv
// Fetch PC selection for the Y86-64 pipeline: owns the predicted-PC register and a
// circular return-address stack, and steers f_PC on M-stage jXX or W-stage ret redirects.
module fetch_pc_unit #(
    parameter int                ADDR_W    = 64,
    parameter int                RAS_DEPTH = 8,
    parameter bit                USE_RAS   = 1'b1,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              F_stall,
    input  logic [3:0]        f_icode,
    input  logic [ADDR_W-1:0] f_valC,
    input  logic [ADDR_W-1:0] f_valP,
    input  logic [3:0]        M_icode,
    input  logic              M_cnd,
    input  logic [ADDR_W-1:0] M_valA,
    input  logic [3:0]        W_icode,
    input  logic [ADDR_W-1:0] W_valM,
    input  logic              W_ret_pred,
    input  logic [ADDR_W-1:0] W_pred_target,
    output logic [ADDR_W-1:0] f_PC,
    output logic [ADDR_W-1:0] F_predPC,
    output logic              f_ret_pred,
    output logic [ADDR_W-1:0] f_ret_target,
    output logic              redirect,
    output logic [31:0]       redirect_cnt
);
    localparam logic [3:0] I_JXX  = 4'd7;
    localparam logic [3:0] I_CALL = 4'd8;
    localparam logic [3:0] I_RET  = 4'd9;
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

    logic [ADDR_W-1:0] ras_r [RAS_DEPTH];
    logic [PTR_W-1:0]  ptr_r;
    logic [CNT_W-1:0]  count_r;

    logic              mis_j_s;
    logic              mis_r_s;
    logic              clear_s;
    logic [CNT_W-1:0]  eff_cnt_s;
    logic              hit_s;
    logic [ADDR_W-1:0] ras_top_s;
    logic [ADDR_W-1:0] next_pc_s;

    // Redirect detection, f_PC priority select and the effective (post-flush) RAS view
    always_comb begin
        mis_j_s   = (M_icode == I_JXX) && !M_cnd;
        mis_r_s   = (W_icode == I_RET) && (!W_ret_pred || (W_valM != W_pred_target));
        redirect  = mis_j_s || mis_r_s;
        if (mis_j_s) begin
            f_PC = M_valA;
        end else if (mis_r_s) begin
            f_PC = W_valM;
        end else begin
            f_PC = F_predPC;
        end
        // A flushing redirect empties the stack before the newly fetched op sees it
        clear_s   = redirect && !F_stall;
        eff_cnt_s = clear_s ? '0 : count_r;
        hit_s     = USE_RAS && (eff_cnt_s != '0);
        ras_top_s = ras_r[ptr_r - PTR_W'(1)];
    end

    // Next-PC prediction and ret-prediction outputs
    always_comb begin
        f_ret_pred   = (f_icode == I_RET) && hit_s;
        f_ret_target = f_ret_pred ? ras_top_s : '0;
        case (f_icode)
            I_JXX, I_CALL: next_pc_s = f_valC;
            I_RET:         next_pc_s = hit_s ? ras_top_s : f_valP;
            default:       next_pc_s = f_valP;
        endcase
    end

    // Predicted-PC register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            F_predPC <= RESET_PC;
        end else if (!F_stall) begin
            F_predPC <= next_pc_s;
        end
    end

    // Circular return-address stack; a full stack overwrites its oldest entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r   <= '0;
            count_r <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_r[i] <= '0;
            end
        end else if (!F_stall) begin
            if (f_icode == I_CALL) begin
                ras_r[ptr_r] <= f_valP;
                ptr_r        <= ptr_r + PTR_W'(1);
                count_r      <= (eff_cnt_s == CNT_MAX) ? CNT_MAX : eff_cnt_s + CNT_W'(1);
            end else if ((f_icode == I_RET) && hit_s) begin
                ptr_r   <= ptr_r - PTR_W'(1);
                count_r <= eff_cnt_s - CNT_W'(1);
            end else begin
                count_r <= eff_cnt_s;
            end
        end
    end

    // Saturating redirect counter, counts even while fetch is stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect_cnt <= 32'd0;
        end else if (redirect && (redirect_cnt != 32'hFFFF_FFFF)) begin
            redirect_cnt <= redirect_cnt + 32'd1;
        end
    end
endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed scenarios then random traffic,
// all checked against a queue-based reference model of the prediction rules.
module tb_fetch_pc_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        F_stall = 1'b0;
    logic [3:0]  f_icode = 4'd0;
    logic [63:0] f_valC = 64'd0, f_valP = 64'd0;
    logic [3:0]  M_icode = 4'd0;
    logic        M_cnd = 1'b1;
    logic [63:0] M_valA = 64'd0;
    logic [3:0]  W_icode = 4'd0;
    logic [63:0] W_valM = 64'd0;
    logic        W_ret_pred = 1'b0;
    logic [63:0] W_pred_target = 64'd0;

    logic [63:0] f_PC, F_predPC, f_ret_target;
    logic        f_ret_pred, redirect;
    logic [31:0] redirect_cnt;
    logic [63:0] nr_f_PC, nr_F_predPC, nr_f_ret_target;
    logic        nr_f_ret_pred, nr_redirect;
    logic [31:0] nr_redirect_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [63:0] m_pred;
    logic [63:0] ras_q[$];
    logic [31:0] m_cnt;

    always #5 clk = ~clk;

    fetch_pc_unit #(.ADDR_W(64), .RAS_DEPTH(8), .USE_RAS(1'b1), .RESET_PC(64'd0)) dut (
        .clk(clk), .rst(rst), .F_stall(F_stall), .f_icode(f_icode), .f_valC(f_valC),
        .f_valP(f_valP), .M_icode(M_icode), .M_cnd(M_cnd), .M_valA(M_valA),
        .W_icode(W_icode), .W_valM(W_valM), .W_ret_pred(W_ret_pred),
        .W_pred_target(W_pred_target), .f_PC(f_PC), .F_predPC(F_predPC),
        .f_ret_pred(f_ret_pred), .f_ret_target(f_ret_target), .redirect(redirect),
        .redirect_cnt(redirect_cnt)
    );

    fetch_pc_unit #(.ADDR_W(64), .RAS_DEPTH(8), .USE_RAS(1'b0), .RESET_PC(64'd0)) dut_noras (
        .clk(clk), .rst(rst), .F_stall(F_stall), .f_icode(f_icode), .f_valC(f_valC),
        .f_valP(f_valP), .M_icode(M_icode), .M_cnd(M_cnd), .M_valA(M_valA),
        .W_icode(W_icode), .W_valM(W_valM), .W_ret_pred(W_ret_pred),
        .W_pred_target(W_pred_target), .f_PC(nr_f_PC), .F_predPC(nr_F_predPC),
        .f_ret_pred(nr_f_ret_pred), .f_ret_target(nr_f_ret_target), .redirect(nr_redirect),
        .redirect_cnt(nr_redirect_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pred = 64'd0;
        ras_q.delete();
        m_cnt = 32'd0;
    endtask

    task automatic bubble();
        F_stall = 1'b0; M_icode = 4'd0; M_cnd = 1'b1; W_icode = 4'd0; W_ret_pred = 1'b0;
    endtask

    // Checks combinational outputs before the edge and registers after it
    task automatic step();
        logic mj, mr, rd, clr, hit, is_ret;
        logic [63:0] top, efpc, nxt;
        #2;
        mj     = (M_icode == 4'd7) && !M_cnd;
        mr     = (W_icode == 4'd9) && (!W_ret_pred || (W_valM != W_pred_target));
        rd     = mj || mr;
        clr    = rd && !F_stall;
        hit    = !clr && (ras_q.size() > 0);
        top    = hit ? ras_q[$] : 64'd0;
        is_ret = (f_icode == 4'd9);
        efpc   = mj ? M_valA : (mr ? W_valM : m_pred);
        if (f_icode == 4'd7 || f_icode == 4'd8) nxt = f_valC;
        else if (is_ret && hit)                 nxt = top;
        else                                    nxt = f_valP;
        chk("f_PC", f_PC, efpc);
        chk("redirect", {63'd0, redirect}, {63'd0, rd});
        chk("f_ret_pred", {63'd0, f_ret_pred}, {63'd0, is_ret && hit});
        chk("f_ret_target", f_ret_target, (is_ret && hit) ? top : 64'd0);
        chk("noras_ret_pred", {63'd0, nr_f_ret_pred}, 64'd0);
        chk("noras_ret_target", nr_f_ret_target, 64'd0);
        chk("noras_redirect", {63'd0, nr_redirect}, {63'd0, rd});
        @(posedge clk);
        if (!F_stall) begin
            m_pred = nxt;
            if (clr) ras_q.delete();
            if (f_icode == 4'd8) begin
                ras_q.push_back(f_valP);
                if (ras_q.size() > 8) void'(ras_q.pop_front());
            end else if (is_ret && hit) begin
                void'(ras_q.pop_back());
            end
        end
        if (rd && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
        #1;
        chk("F_predPC", F_predPC, m_pred);
        chk("redirect_cnt", {32'd0, redirect_cnt}, {32'd0, m_cnt});
        chk("noras_redirect_cnt", {32'd0, nr_redirect_cnt}, {32'd0, m_cnt});
    endtask

    initial begin
        model_reset();
        // 1. Reset
        #3;
        chk("rst_f_PC", f_PC, 64'd0);
        chk("rst_F_predPC", F_predPC, 64'd0);
        chk("rst_redirect_cnt", {32'd0, redirect_cnt}, 64'd0);
        chk("rst_redirect", {63'd0, redirect}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        f_icode = 4'd0; f_valP = 64'd1;
        step();
        chk("t1_predPC", F_predPC, 64'd1);

        // 2. Jump predict then mispredict
        f_icode = 4'd7; f_valC = 64'h40; f_valP = 64'h2;
        step();
        chk("t2_predPC", F_predPC, 64'h40);
        f_icode = 4'd8; f_valC = 64'h50; f_valP = 64'h49;
        step();
        f_icode = 4'd0; f_valP = 64'h0B;
        M_icode = 4'd7; M_cnd = 1'b0; M_valA = 64'h0A;
        #1;
        chk("t2_f_PC", f_PC, 64'h0A);
        chk("t2_redirect", {63'd0, redirect}, 64'd1);
        step();
        chk("t2_cnt", {32'd0, redirect_cnt}, 64'd1);
        bubble();
        f_icode = 4'd9; f_valP = 64'h0C;
        #1;
        chk("t2_ras_cleared", {63'd0, f_ret_pred}, 64'd0);
        step();

        // 3. Call/ret hit
        f_icode = 4'd8; f_valC = 64'h500; f_valP = 64'h100;
        step();
        f_icode = 4'd9; f_valP = 64'h509;
        #1;
        chk("t3_ret_pred", {63'd0, f_ret_pred}, 64'd1);
        chk("t3_ret_target", f_ret_target, 64'h100);
        step();
        chk("t3_predPC", F_predPC, 64'h100);
        f_icode = 4'd0; f_valP = 64'h101;
        W_icode = 4'd9; W_ret_pred = 1'b1; W_valM = 64'h100; W_pred_target = 64'h100;
        #1;
        chk("t3_no_redirect", {63'd0, redirect}, 64'd0);
        step();

        // 4. Ret mismatch, then simultaneous jXX mispredict
        W_valM = 64'h200;
        #1;
        chk("t4_f_PC", f_PC, 64'h200);
        chk("t4_redirect", {63'd0, redirect}, 64'd1);
        step();
        M_icode = 4'd7; M_cnd = 1'b0; M_valA = 64'h30;
        #1;
        chk("t4_prio_f_PC", f_PC, 64'h30);
        step();
        bubble();

        // 5. RAS overflow
        for (int k = 1; k <= 9; k++) begin
            f_icode = 4'd8; f_valC = 64'h1000; f_valP = 64'(k * 16);
            step();
        end
        for (int k = 0; k < 8; k++) begin
            f_icode = 4'd9; f_valP = 64'h2000 + 64'(k);
            #1;
            chk("t5_ret_target", f_ret_target, 64'(144 - 16 * k));
            step();
        end
        f_icode = 4'd9; f_valP = 64'h3000;
        #1;
        chk("t5_empty_ret_pred", {63'd0, f_ret_pred}, 64'd0);
        step();
        chk("t5_predPC_fallthru", F_predPC, 64'h3000);

        // 6. Stall, then async reset mid-cycle
        f_icode = 4'd8; f_valC = 64'h600; f_valP = 64'h700;
        step();
        F_stall = 1'b1; f_icode = 4'd8; f_valC = 64'h800; f_valP = 64'h900;
        step();
        chk("t6_stall_predPC", F_predPC, 64'h600);
        F_stall = 1'b0; f_icode = 4'd9; f_valP = 64'h601;
        #1;
        chk("t6_stall_ras", f_ret_target, 64'h700);
        f_icode = 4'd8; f_valP = 64'h650;
        step();
        rst = 1'b1;
        #1;
        chk("t6_arst_predPC", F_predPC, 64'd0);
        chk("t6_arst_cnt", {32'd0, redirect_cnt}, 64'd0);
        chk("t6_arst_f_PC", f_PC, 64'd0);
        model_reset();
        #1;
        rst = 1'b0;
        f_icode = 4'd9; f_valP = 64'h44;
        step();

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 4))
                0: f_icode = 4'd7;
                1, 2: f_icode = 4'd8;
                3: f_icode = 4'd9;
                default: f_icode = 4'($urandom_range(0, 11));
            endcase
            f_valC = {32'd0, $urandom};
            f_valP = {32'd0, $urandom};
            F_stall = ($urandom_range(0, 4) == 0);
            M_icode = ($urandom_range(0, 5) == 0) ? 4'd7 : 4'd0;
            M_cnd = 1'($urandom_range(0, 1));
            M_valA = {32'd0, $urandom};
            W_icode = ($urandom_range(0, 5) == 0) ? 4'd9 : 4'd6;
            W_ret_pred = ($urandom_range(0, 3) != 0);
            W_valM = {32'd0, $urandom};
            W_pred_target = ($urandom_range(0, 1) == 1) ? W_valM : {32'd0, $urandom};
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
